// File: rtl/pad_cmd_sched.sv
// Pad command scheduler: in-order command FIFO, SRAM0 range check, one-at-a-time
// issue to the pad engine, tagged completions. Optional PAD_SCHED_PERF_EN adds perf counters.
module pad_cmd_sched #(
  parameter int DEPTH    = 4,
  parameter int SRAM0_AW = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_src_base,
  input  logic [15:0]                in_dst_base,
  input  logic [15:0]                in_C,
  input  logic [15:0]                in_H,
  input  logic [15:0]                in_W,
  input  logic [7:0]                 in_pad_top,
  input  logic [7:0]                 in_pad_bottom,
  input  logic [7:0]                 in_pad_left,
  input  logic [7:0]                 in_pad_right,
  input  logic [7:0]                 in_tag,
  input  logic                       sw_flush,
  output logic                       pe_cmd_valid,
  output logic [15:0]                pe_src_base,
  output logic [15:0]                pe_dst_base,
  output logic [15:0]                pe_C,
  output logic [15:0]                pe_H,
  output logic [15:0]                pe_W,
  output logic [7:0]                 pe_pad_top,
  output logic [7:0]                 pe_pad_bottom,
  output logic [7:0]                 pe_pad_left,
  output logic [7:0]                 pe_pad_right,
  input  logic                       pe_busy,
  input  logic                       pe_done,
  output logic                       cpl_valid,
  output logic [7:0]                 cpl_tag,
  output logic [1:0]                 cpl_status,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       busy,
`ifdef PAD_SCHED_PERF_EN
  output logic [31:0]                cpl_cycles,
  output logic [31:0]                total_busy_cycles,
`endif
  output logic [15:0]                done_count,
  output logic [15:0]                err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] c;
    logic [15:0] h;
    logic [15:0] w;
    logic [7:0]  pt;
    logic [7:0]  pb;
    logic [7:0]  pl;
    logic [7:0]  pr;
    logic [7:0]  tag;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_RUN, S_CPL} state_t;

  state_t         state;
  cmd_t           mem [DEPTH];
  cmd_t           in_cmd;
  cmd_t           work;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [1:0]     status;
  logic           push;
  logic           pop;
  logic           full;

  logic [16:0]    out_h;
  logic [16:0]    out_w;
  logic [51:0]    dst_end;
  logic [51:0]    src_end;
  logic [51:0]    limit;
  logic           is_empty;
  logic           is_illegal;

  assign in_cmd = '{src: in_src_base, dst: in_dst_base, c: in_C, h: in_H, w: in_W,
                    pt: in_pad_top, pb: in_pad_bottom, pl: in_pad_left,
                    pr: in_pad_right, tag: in_tag};

  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full && !sw_flush;
  assign push     = in_valid && in_ready;
  // A flush discards the head too, so no pop may race it in the same cycle.
  assign pop      = (state == S_IDLE) && (count != '0) && !sw_flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (sw_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // End addresses are widened to 52 bits so the product can never wrap.
  always_comb begin
    out_h      = 17'(work.h) + 17'(work.pt) + 17'(work.pb);
    out_w      = 17'(work.w) + 17'(work.pl) + 17'(work.pr);
    dst_end    = 52'(work.dst) + 52'(work.c) * 52'(out_h) * 52'(out_w);
    src_end    = 52'(work.src) + 52'(work.c) * 52'(work.h) * 52'(work.w);
    limit      = 52'(1) << SRAM0_AW;
    is_empty   = (work.c == '0) || (work.h == '0) || (work.w == '0);
    is_illegal = (dst_end > limit) || (src_end > limit) || out_h[16] || out_w[16];
  end

`ifdef PAD_SCHED_PERF_EN
  logic [31:0] run_cycles;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      work       <= '0;
      status     <= 2'd0;
      done_count <= '0;
      err_count  <= '0;
`ifdef PAD_SCHED_PERF_EN
      run_cycles        <= '0;
      total_busy_cycles <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            work   <= mem[rd_ptr];
            status <= 2'd0;
            state  <= S_CHECK;
`ifdef PAD_SCHED_PERF_EN
            run_cycles <= '0;
`endif
          end
        end
        S_CHECK: begin
          if (is_empty) begin
            status <= 2'd1;
            state  <= S_CPL;
          end else if (is_illegal) begin
            status <= 2'd2;
            state  <= S_CPL;
          end else begin
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!pe_busy) begin
            state <= S_RUN;
`ifdef PAD_SCHED_PERF_EN
            run_cycles <= 32'd1;
`endif
          end
        end
        S_RUN: begin
`ifdef PAD_SCHED_PERF_EN
          run_cycles <= run_cycles + 32'd1;
          if (total_busy_cycles != 32'hFFFF_FFFF) total_busy_cycles <= total_busy_cycles + 32'd1;
`endif
          if (pe_done) begin
            status <= 2'd0;
            state  <= S_CPL;
          end
        end
        S_CPL: begin
          if (status == 2'd0) done_count <= done_count + 16'd1;
          if (status == 2'd2) err_count  <= err_count + 16'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pe_cmd_valid  = (state == S_ISSUE) && !pe_busy;
  assign pe_src_base   = work.src;
  assign pe_dst_base   = work.dst;
  assign pe_C          = work.c;
  assign pe_H          = work.h;
  assign pe_W          = work.w;
  assign pe_pad_top    = work.pt;
  assign pe_pad_bottom = work.pb;
  assign pe_pad_left   = work.pl;
  assign pe_pad_right  = work.pr;
  assign cpl_valid     = (state == S_CPL);
  assign cpl_tag       = work.tag;
  assign cpl_status    = status;
  assign q_count       = count;
  assign busy          = (state != S_IDLE) || (count != '0);

`ifdef PAD_SCHED_PERF_EN
  assign cpl_cycles = ((state == S_CPL) && (status == 2'd0)) ? run_cycles : 32'd0;
`endif

endmodule

// File: tb/tb_pad_cmd_sched.sv
// Scoreboard bench for pad_cmd_sched: expected issues/completions are queued at push
// and popped by monitors when the DUT issues or completes.
module tb_pad_cmd_sched;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] c;
    logic [15:0] h;
    logic [15:0] w;
    logic [7:0]  pt;
    logic [7:0]  pb;
    logic [7:0]  pl;
    logic [7:0]  pr;
    logic [7:0]  tag;
  } cmd_t;

  typedef struct packed {
    logic [7:0] tag;
    logic [1:0] status;
  } cpl_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_src_base = 0, in_dst_base = 0, in_C = 0, in_H = 0, in_W = 0;
  logic [7:0]  in_pad_top = 0, in_pad_bottom = 0, in_pad_left = 0, in_pad_right = 0;
  logic [7:0]  in_tag = 0;
  logic        sw_flush = 0;
  logic        pe_cmd_valid;
  logic [15:0] pe_src_base, pe_dst_base, pe_C, pe_H, pe_W;
  logic [7:0]  pe_pad_top, pe_pad_bottom, pe_pad_left, pe_pad_right;
  logic        pe_busy;
  logic        pe_done;
  logic        cpl_valid;
  logic [7:0]  cpl_tag;
  logic [1:0]  cpl_status;
  logic [2:0]  q_count;
  logic        busy;
  logic [15:0] done_count, err_count;
`ifdef PAD_SCHED_PERF_EN
  logic [31:0] cpl_cycles, total_busy_cycles;
`endif

  pad_cmd_sched #(.DEPTH(4), .SRAM0_AW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_src_base(in_src_base), .in_dst_base(in_dst_base),
    .in_C(in_C), .in_H(in_H), .in_W(in_W),
    .in_pad_top(in_pad_top), .in_pad_bottom(in_pad_bottom),
    .in_pad_left(in_pad_left), .in_pad_right(in_pad_right),
    .in_tag(in_tag), .sw_flush(sw_flush),
    .pe_cmd_valid(pe_cmd_valid), .pe_src_base(pe_src_base), .pe_dst_base(pe_dst_base),
    .pe_C(pe_C), .pe_H(pe_H), .pe_W(pe_W),
    .pe_pad_top(pe_pad_top), .pe_pad_bottom(pe_pad_bottom),
    .pe_pad_left(pe_pad_left), .pe_pad_right(pe_pad_right),
    .pe_busy(pe_busy), .pe_done(pe_done),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_status(cpl_status),
    .q_count(q_count), .busy(busy),
`ifdef PAD_SCHED_PERF_EN
    .cpl_cycles(cpl_cycles), .total_busy_cycles(total_busy_cycles),
`endif
    .done_count(done_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int push_cyc = 0;
  int issue_cyc = 0;
  int cpl_cyc = 0;
  int n_issue = 0;
  int n_cpl = 0;
  int exp_done = 0;
  int exp_err = 0;
  int eng_delay = 5;
  logic force_busy = 0;
  logic eng_active;
  int   eng_cnt;
  cmd_t exp_issue[$];
  cpl_t exp_cpl[$];

  task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: done pulses eng_delay cycles after the issue strobe.
  assign pe_busy = eng_active || force_busy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_active <= 0;
      eng_cnt    <= 0;
      pe_done    <= 0;
    end else begin
      pe_done <= 0;
      if (pe_cmd_valid) begin
        eng_active <= 1;
        eng_cnt    <= eng_delay;
      end else if (eng_active) begin
        if (eng_cnt == 1) begin
          pe_done    <= 1;
          eng_active <= 0;
        end else eng_cnt <= eng_cnt - 1;
      end
    end
  end

  function automatic logic [1:0] expStatus(input cmd_t c);
    longint unsigned oh, ow, d_end, s_end, lim;
    oh    = longint'(c.h) + longint'(c.pt) + longint'(c.pb);
    ow    = longint'(c.w) + longint'(c.pl) + longint'(c.pr);
    d_end = longint'(c.dst) + longint'(c.c) * oh * ow;
    s_end = longint'(c.src) + longint'(c.c) * longint'(c.h) * longint'(c.w);
    lim   = 64'd65536;
    if (c.c == 0 || c.h == 0 || c.w == 0) return 2'd1;
    if (d_end > lim || s_end > lim || oh > 65535 || ow > 65535) return 2'd2;
    return 2'd0;
  endfunction

  function automatic cmd_t mk(input logic [15:0] src, dst, c, h, w,
                              input logic [7:0] pt, pb, pl, pr, tag);
    return '{src: src, dst: dst, c: c, h: h, w: w, pt: pt, pb: pb, pl: pl, pr: pr, tag: tag};
  endfunction

  // Monitors sample mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pe_cmd_valid) begin
        cmd_t e;
        issue_cyc = cyc;
        n_issue++;
        checkOutput("issue_while_busy", pe_busy, 1'b0);
        if (exp_issue.size() == 0) checkOutput("unexpected_issue", 1'b1, 1'b0);
        else begin
          e = exp_issue.pop_front();
          checkOutput("issue_fields",
            {pe_src_base, pe_dst_base, pe_C, pe_H, pe_W, pe_pad_top, pe_pad_bottom, pe_pad_left, pe_pad_right},
            {e.src, e.dst, e.c, e.h, e.w, e.pt, e.pb, e.pl, e.pr});
        end
      end
      if (cpl_valid) begin
        cpl_t e;
        cpl_cyc = cyc;
        n_cpl++;
        if (exp_cpl.size() == 0) checkOutput("unexpected_cpl", 1'b1, 1'b0);
        else begin
          e = exp_cpl.pop_front();
          checkOutput("cpl_tag_status", {cpl_tag, cpl_status}, {e.tag, e.status});
          if (e.status == 2'd0) exp_done++;
          if (e.status == 2'd2) exp_err++;
        end
      end
    end
  end

  task automatic applyStimulus(input cmd_t c);
    int waited = 0;
    logic [1:0] st;
    in_valid = 1;
    {in_src_base, in_dst_base, in_C, in_H, in_W} = {c.src, c.dst, c.c, c.h, c.w};
    {in_pad_top, in_pad_bottom, in_pad_left, in_pad_right, in_tag} = {c.pt, c.pb, c.pl, c.pr, c.tag};
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checkOutput("push_timeout", 1'b0, 1'b1);
      in_valid = 0;
      return;
    end
    push_cyc = cyc;
    st = expStatus(c);
    exp_cpl.push_back('{tag: c.tag, status: st});
    if (st == 2'd0) exp_issue.push_back(c);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic waitDrain(input int budget);
    int waited = 0;
    while ((exp_cpl.size() != 0 || busy) && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("drain_timeout", (exp_cpl.size() != 0 || busy), 1'b0);
  endtask

  task automatic waitIssue(input int start, input int budget);
    int waited = 0;
    while (n_issue == start && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("issue_timeout", n_issue == start, 1'b0);
  endtask

  task automatic checkCounters(input string name);
    checkOutput(name, {done_count, err_count}, {exp_done[15:0], exp_err[15:0]});
  endtask

  initial begin
    int base_issue;
    int base_cpl;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_zero", |{q_count, busy, pe_cmd_valid, cpl_valid, cpl_tag, cpl_status,
                               done_count, err_count, pe_src_base, pe_dst_base, pe_C, pe_H, pe_W,
                               pe_pad_top, pe_pad_bottom, pe_pad_left, pe_pad_right}, 1'b0);
    rst_n = 1;
    @(negedge clk);

    $display("[TB] test 1: single command");
    eng_delay = 20;
    base_issue = n_issue;
    applyStimulus(mk(16'h0100, 16'h2000, 16'd1, 16'd2, 16'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'h11));
    waitDrain(200);
    checkOutput("t1_issue_latency", 32'(issue_cyc - push_cyc), 32'd3);
    checkOutput("t1_issue_count", 32'(n_issue - base_issue), 32'd1);
    checkCounters("t1_counters");

    $display("[TB] test 2: backpressure and ordering");
    eng_delay = 5;
    force_busy = 1;
    for (int i = 0; i < 5; i++)
      applyStimulus(mk(16'(i * 16), 16'(16'h4000 + i * 64), 16'd2, 16'd3, 16'd3,
                       8'd0, 8'd1, 8'd0, 8'd1, 8'(i)));
    checkOutput("t2_full_count", q_count, 3'd4);
    checkOutput("t2_in_ready_low", in_ready, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("t2_no_issue_busy", exp_issue.size(), 32'd5);
    force_busy = 0;
    waitDrain(400);
    checkCounters("t2_counters");

    $display("[TB] test 3: empty command");
    base_issue = n_issue;
    applyStimulus(mk(16'h0000, 16'h0000, 16'd4, 16'd0, 16'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'h22));
    waitDrain(50);
    checkOutput("t3_no_issue", 32'(n_issue - base_issue), 32'd0);
    checkOutput("t3_cpl_latency", 32'(cpl_cyc - push_cyc), 32'd3);
    checkCounters("t3_counters");

    $display("[TB] test 4: range boundary");
    applyStimulus(mk(16'h0000, 16'hFF00, 16'd1, 16'd16, 16'd16, 8'd0, 8'd0, 8'd0, 8'd0, 8'h33));
    waitDrain(100);
    base_issue = n_issue;
    applyStimulus(mk(16'h0000, 16'hFF00, 16'd1, 16'd16, 16'd16, 8'd0, 8'd0, 8'd0, 8'd1, 8'h34));
    waitDrain(100);
    checkOutput("t4_err_no_issue", 32'(n_issue - base_issue), 32'd0);
    checkCounters("t4_counters");

    $display("[TB] test 5: flush");
    eng_delay = 40;
    base_issue = n_issue;
    applyStimulus(mk(16'h0000, 16'h1000, 16'd1, 16'd4, 16'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'h50));
    waitIssue(base_issue, 50);
    for (int i = 1; i <= 3; i++)
      applyStimulus(mk(16'h0000, 16'h1000, 16'd1, 16'd4, 16'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'(8'h50 + i)));
    checkOutput("t5_queued", q_count, 3'd3);
    sw_flush = 1;
    in_valid = 1;
    in_tag = 8'h77;
    #1 checkOutput("t5_flush_ready", in_ready, 1'b0);
    @(negedge clk);
    sw_flush = 0;
    in_valid = 0;
    checkOutput("t5_flushed_count", q_count, 3'd0);
    while (exp_cpl.size() > 1) void'(exp_cpl.pop_back());
    exp_issue.delete();
    base_issue = n_issue;
    waitDrain(200);
    base_cpl = n_cpl;
    repeat (20) @(negedge clk);
    checkOutput("t5_quiet", {32'(n_issue - base_issue), 32'(n_cpl - base_cpl)}, 64'd0);
    checkCounters("t5_counters");

    $display("[TB] test 6: reset in run");
    eng_delay = 50;
    base_issue = n_issue;
    applyStimulus(mk(16'h0000, 16'h0800, 16'd2, 16'd2, 16'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'h60));
    waitIssue(base_issue, 50);
    repeat (3) @(negedge clk);
    base_cpl = n_cpl;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_reset_in_ready", in_ready, 1'b1);
    checkOutput("t6_reset_zero", |{q_count, busy, pe_cmd_valid, cpl_valid, cpl_tag, cpl_status,
                                  done_count, err_count, pe_src_base, pe_dst_base, pe_C, pe_H, pe_W,
                                  pe_pad_top, pe_pad_bottom, pe_pad_left, pe_pad_right}, 1'b0);
    exp_cpl.delete();
    exp_issue.delete();
    exp_done = 0;
    exp_err = 0;
    rst_n = 1;
    @(negedge clk);
    checkOutput("t6_no_cpl", 32'(n_cpl - base_cpl), 32'd0);
    eng_delay = 5;
    base_issue = n_issue;
    applyStimulus(mk(16'h0010, 16'h0900, 16'd1, 16'd3, 16'd5, 8'd2, 8'd0, 8'd1, 8'd0, 8'h61));
    waitDrain(100);
    checkOutput("t6_reissue_latency", 32'(issue_cyc - push_cyc), 32'd3);
    checkCounters("t6_counters");

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
